uart_tx_buffer: RTL and testbench

Byte FIFO with a transmit sequencer, placed directly upstream of `uart_transceiver`. Producers push bytes in single-cycle write strobes, with no regard to line timing. The block drains the FIFO one byte at a time: it issues a one-cycle `en_i` pulse to the transceiver, then tracks the transceiver's `ready_o` through a full busy/idle cycle before launching the next byte. It replaces the direct `strobe_generator`-to-transceiver path wherever bursts longer than one byte must be sent back to back.

---
 rtl/uart_tx_buffer.sv | 136 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Purpose: byte FIFO feeding uart_transceiver, one launch pulse per byte, paced by tx_ready_i (optional sticky overflow flag: UART_TX_BUF_OVF_EN).
// Latency: push sampled at edge N -> level/empty at N+1 -> tx_en_o high after N+1, sampled by the transceiver at N+2.
// Backpressure: pushes are dropped while full; a busy transceiver (tx_ready_i=0) holds the sequencer in IDLE.
module uart_tx_buffer #(
    parameter int DATA_AMOUNT = 8,
    parameter int DEPTH       = 16,
    parameter int BUSY_TO     = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     wr_en_i,
    input  logic [DATA_AMOUNT-1:0]   data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    input  logic                     tx_ready_i,
    output logic                     tx_en_o,
    output logic [DATA_AMOUNT-1:0]   tx_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BUSY_TO);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          busy_cnt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_AMOUNT-1:0] mem [DEPTH];
    logic                   push;
    logic                   pop;

    // Flags come straight from the registered count, so they never glitch.
    assign full_o  = (level_o == LW'(DEPTH));
    assign empty_o = (level_o == '0);

    // Push is judged on registered fullness; pop only on the IDLE->SEND hand-off.
    assign push = wr_en_i && !full_o;
    assign pop  = (state == IDLE) && !empty_o && tx_ready_i;

    // Storage array carries no reset; only pointer-qualified entries are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy count; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_o <= level_o + LW'(1);
                2'b01:   level_o <= level_o - LW'(1);
                default: level_o <= level_o;
            endcase
        end
    end

`ifdef UART_TX_BUF_OVF_EN
    logic ovf_q;

    // Sticky record of any push that arrived while the buffer was full.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && full_o) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    // Launch sequencer: pulse en once, then follow ready through busy and back to idle,
    // giving up on the busy phase after BUSY_TO cycles if ready never falls.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            tx_en_o   <= 1'b0;
            tx_data_o <= '0;
        end else begin
            tx_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty_o && tx_ready_i) begin
                        tx_data_o <= mem[rd_ptr];
                        tx_en_o   <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    busy_cnt <= CW'(BUSY_TO - 1);
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready_i) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt - CW'(1);
                        if (busy_cnt == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Purpose: self-checking bench for uart_tx_buffer with a behavioural transceiver and expected-byte queues.
// Latency: launches are judged on the edge at which the transceiver samples tx_en_o.
// Backpressure: the transceiver model can stay idle, go busy for a random span, hold busy, or be hand-driven.
module tb_uart_tx_buffer;

    localparam int DEPTH   = 16;
    localparam int BUSY_TO = 16;
    localparam int M_NORMAL = 0;
    localparam int M_NOBUSY = 1;
    localparam int M_HOLD   = 2;
    localparam int M_MANUAL = 3;
`ifdef UART_TX_BUF_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic       clk;
    logic       arst;
    logic       wr_en;
    logic [7:0] data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       tx_ready;
    logic       tx_en;
    logic [7:0] tx_data;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int mode  = M_NORMAL;
    int busy_len = 3;
    int busy_rem = 0;
    int last_rise = 0;
    int dbl = 0;
    bit prev_en = 0;

    logic [7:0] l_dat[$];
    int         l_edge[$];
    int         l_gap[$];

    uart_tx_buffer #(.DATA_AMOUNT(8), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
        .clk_i(clk), .arst_i(arst), .wr_en_i(wr_en), .data_i(data),
        .full_o(full), .empty_o(empty), .level_o(level), .ovf_o(ovf),
        .tx_ready_i(tx_ready), .tx_en_o(tx_en), .tx_data_o(tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transceiver model and launch recorder; a launch is logged with the edge that samples it.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (arst === 1'b1) begin
                if (tx_en === 1'b1) begin
                    l_dat.push_back(tx_data);
                    l_edge.push_back(cyc + 1);
                    l_gap.push_back(cyc + 1 - last_rise);
                    if (prev_en) dbl++;
                end
                prev_en = (tx_en === 1'b1);
            end else begin
                prev_en = 1'b0;
            end
            case (mode)
                M_NORMAL: begin
                    if (tx_en === 1'b1) begin
                        tx_ready = 1'b0;
                        busy_rem = busy_len;
                    end else if (busy_rem > 0) begin
                        busy_rem--;
                        if (busy_rem == 0) begin
                            tx_ready  = 1'b1;
                            last_rise = cyc + 1;
                        end
                    end else if (!tx_ready) begin
                        tx_ready  = 1'b1;
                        last_rise = cyc + 1;
                    end
                end
                M_NOBUSY: tx_ready = 1'b1;
                M_HOLD:   tx_ready = 1'b0;
                default:  ;
            endcase
        end
    end

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1;
        data  = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_log();
        l_dat.delete();
        l_edge.delete();
        l_gap.delete();
    endtask

    task automatic wait_launches(input int n, input int budget);
        for (int i = 0; i < budget && l_dat.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        if (level !== 5'd0)   begin nfail++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (empty !== 1'b1)   begin nfail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0)    begin nfail++; $display("FAIL reset_full: got %b expected 0", full); end
        if (ovf !== 1'b0)     begin nfail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        if (tx_en !== 1'b0)   begin nfail++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        if (tx_data !== 8'h0) begin nfail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        ncmp += 6;
    endtask

    task automatic test_single();
        int pe;
        mode = M_NORMAL; busy_len = 3;
        clear_log();
        pe = cyc + 1;
        push_byte(8'hA5);
        ncmp++;
        if (level !== 5'd1) begin nfail++; $display("FAIL single_level_after_push: got %0d expected 1", level); end
        @(negedge clk);
        ncmp++;
        if (level !== 5'd0) begin nfail++; $display("FAIL single_level_after_pop: got %0d expected 0", level); end
        wait_launches(1, 20);
        ncmp++;
        if (l_dat.size() != 1) begin
            nfail++; $display("FAIL single_launch_count: got %0d expected 1", l_dat.size());
        end else begin
            ncmp += 2;
            if (l_edge[0] != pe + 2) begin nfail++; $display("FAIL single_latency: got %0d expected %0d", l_edge[0] - pe, 2); end
            if (l_dat[0] !== 8'hA5)  begin nfail++; $display("FAIL single_data: got %h expected a5", l_dat[0]); end
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_burst();
        int pe;
        mode = M_NORMAL; busy_len = $urandom_range(2, 6);
        clear_log();
        pe = cyc + 1;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        wait_launches(5, 200);
        ncmp++;
        if (l_dat.size() != 5) begin
            nfail++; $display("FAIL burst_count: got %0d expected 5", l_dat.size());
        end else begin
            ncmp++;
            if (l_edge[0] != pe + 2) begin nfail++; $display("FAIL burst_first_latency: got %0d expected 2", l_edge[0] - pe); end
            for (int i = 0; i < 5; i++) begin
                ncmp++;
                if (l_dat[i] !== 8'(i + 1)) begin nfail++; $display("FAIL burst_data[%0d]: got %h expected %h", i, l_dat[i], 8'(i + 1)); end
                if (i > 0) begin
                    ncmp++;
                    if (l_gap[i] != 2) begin nfail++; $display("FAIL burst_gap[%0d]: got %0d expected 2", i, l_gap[i]); end
                end
            end
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_full_overflow();
        logic [7:0] pushed[$];
        mode = M_HOLD;
        repeat (3) @(negedge clk);
        clear_log();
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            pushed.push_back(b);
            push_byte(b);
            if (i == DEPTH - 1) begin
                ncmp += 3;
                if (full !== 1'b1)          begin nfail++; $display("FAIL full_after_depth: got %b expected 1", full); end
                if (level !== 5'(DEPTH))    begin nfail++; $display("FAIL level_at_depth: got %0d expected %0d", level, DEPTH); end
                if (ovf !== 1'b0)           begin nfail++; $display("FAIL ovf_before_drop: got %b expected 0", ovf); end
            end
        end
        ncmp += 3;
        if (level !== 5'(DEPTH)) begin nfail++; $display("FAIL level_after_drop: got %0d expected %0d", level, DEPTH); end
        if (full !== 1'b1)       begin nfail++; $display("FAIL full_after_drop: got %b expected 1", full); end
        if (ovf !== OVF_EXP)     begin nfail++; $display("FAIL ovf_after_drop: got %b expected %b", ovf, OVF_EXP); end
        busy_rem = 0; busy_len = 2; mode = M_NORMAL;
        wait_launches(DEPTH, DEPTH * 20);
        repeat (40) @(negedge clk);
        ncmp++;
        if (l_dat.size() != DEPTH) begin
            nfail++; $display("FAIL full_drain_count: got %0d expected %0d", l_dat.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ncmp++;
                if (l_dat[i] !== pushed[i]) begin nfail++; $display("FAIL full_drain_data[%0d]: got %h expected %h", i, l_dat[i], pushed[i]); end
            end
        end
        ncmp++;
        if (empty !== 1'b1) begin nfail++; $display("FAIL full_drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp[$];
        mode = M_MANUAL; busy_rem = 0;
        tx_ready = 1'b0;
        @(negedge clk);
        clear_log();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp.push_back(b);
            push_byte(b);
        end
        ncmp++;
        if (level !== 5'd3) begin nfail++; $display("FAIL simul_pre_level: got %0d expected 3", level); end
        exp.push_back(8'h5C);
        tx_ready = 1'b1;
        wr_en = 1'b1;
        data = 8'h5C;
        @(negedge clk);
        wr_en = 1'b0;
        tx_ready = 1'b0;
        ncmp += 2;
        if (level !== 5'd3) begin nfail++; $display("FAIL simul_level: got %0d expected 3", level); end
        if (tx_en !== 1'b1) begin nfail++; $display("FAIL simul_launch: got %b expected 1", tx_en); end
        repeat (2) @(negedge clk);
        busy_len = 2; mode = M_NORMAL;
        wait_launches(4, 100);
        repeat (10) @(negedge clk);
        ncmp++;
        if (l_dat.size() != 4) begin
            nfail++; $display("FAIL simul_count: got %0d expected 4", l_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ncmp++;
                if (l_dat[i] !== exp[i]) begin nfail++; $display("FAIL simul_order[%0d]: got %h expected %h", i, l_dat[i], exp[i]); end
            end
        end
    endtask

    task automatic test_busy_timeout();
        logic [7:0] exp[$];
        mode = M_NOBUSY;
        @(negedge clk);
        clear_log();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp.push_back(b);
            push_byte(b);
        end
        wait_launches(3, 150);
        ncmp++;
        if (l_dat.size() != 3) begin
            nfail++; $display("FAIL timeout_count: got %0d expected 3", l_dat.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                ncmp++;
                if (l_dat[i] !== exp[i]) begin nfail++; $display("FAIL timeout_data[%0d]: got %h expected %h", i, l_dat[i], exp[i]); end
                if (i > 0) begin
                    ncmp++;
                    if (l_edge[i] - l_edge[i-1] != BUSY_TO + 1) begin
                        nfail++; $display("FAIL timeout_spacing[%0d]: got %0d expected %0d", i, l_edge[i] - l_edge[i-1], BUSY_TO + 1);
                    end
                end
            end
        end
        repeat (BUSY_TO + 5) @(negedge clk);
        mode = M_NORMAL;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        mode = M_NORMAL; busy_len = $urandom_range(2, 6);
        repeat (2) @(negedge clk);
        clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp.push_back(b);
            push_byte(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_launches(DEPTH, 400);
        repeat (40) @(negedge clk);
        ncmp++;
        if (l_dat.size() != DEPTH) begin
            nfail++; $display("FAIL random_count: got %0d expected %0d", l_dat.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ncmp++;
                if (l_dat[i] !== exp[i]) begin nfail++; $display("FAIL random_data[%0d]: got %h expected %h", i, l_dat[i], exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int i;
        mode = M_MANUAL; busy_rem = 0;
        tx_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) push_byte(8'($urandom_range(1, 255)));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (level !== 5'd4) begin nfail++; $display("FAIL midrst_pre_level: got %0d expected 4", level); end
        arst = 1'b0;
        #1;
        ncmp += 6;
        if (level !== 5'd0)   begin nfail++; $display("FAIL midrst_level: got %0d expected 0", level); end
        if (empty !== 1'b1)   begin nfail++; $display("FAIL midrst_empty: got %b expected 1", empty); end
        if (full !== 1'b0)    begin nfail++; $display("FAIL midrst_full: got %b expected 0", full); end
        if (ovf !== 1'b0)     begin nfail++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
        if (tx_en !== 1'b0)   begin nfail++; $display("FAIL midrst_tx_en: got %b expected 0", tx_en); end
        if (tx_data !== 8'h0) begin nfail++; $display("FAIL midrst_tx_data: got %h expected 00", tx_data); end
        @(negedge clk);
        arst = 1'b1;
        tx_ready = 1'b1;
        clear_log();
        repeat (25) @(negedge clk);
        ncmp++;
        if (l_dat.size() != 0) begin nfail++; $display("FAIL midrst_spurious_launch: got %0d expected 0", l_dat.size()); end
        push_byte(8'h3C);
        i = 0;
        while (tx_en !== 1'b1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        ncmp += 2;
        if (tx_en !== 1'b1)    begin nfail++; $display("FAIL post_rst_launch: got %b expected 1", tx_en); end
        if (tx_data !== 8'h3C) begin nfail++; $display("FAIL post_rst_data: got %h expected 3c", tx_data); end
        #1;
        arst = 1'b0;
        #1;
        ncmp++;
        if (tx_en !== 1'b0) begin nfail++; $display("FAIL async_en_drop: got %b expected 0", tx_en); end
        @(negedge clk);
        arst = 1'b1;
        mode = M_NORMAL;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        arst  = 1'b0;
        wr_en = 1'b0;
        data  = 8'h0;
        repeat (3) @(negedge clk);
        test_reset();
        arst = 1'b1;
        repeat (2) @(negedge clk);
        test_single();
        test_burst();
        test_full_overflow();
        test_simultaneous();
        test_busy_timeout();
        test_random();
        test_reset_mid_burst();
        ncmp++;
        if (dbl != 0) begin nfail++; $display("FAIL back_to_back_en: got %0d double pulses expected 0", dbl); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
